// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [31:0] NOP_INSN       = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int          MD_LATENCY_DEF = 4;
  localparam int          CNT_W_DEF      = 4;

endpackage

// File: rtl/md_occupancy_fsm.sv
// Mult/div occupancy of the X stage: issues the go pulse, then holds X for
// MD_LATENCY further cycles, flagging the final one as done.
module md_occupancy_fsm
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic md_req_i,
  output logic md_go_o,
  output logic md_busy_o,
  output logic md_done_o,
  output logic md_hold_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_go_o   = 1'b0;
    md_busy_o = 1'b0;
    md_done_o = 1'b0;
    md_hold_o = 1'b0;
    if (reset) begin
      state_d = RUN;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        RUN: begin
          if (md_req_i) begin
            md_go_o = 1'b1;
            state_d = MD_BUSY;
            cnt_d   = CNT_W'(MD_LATENCY - 1);
          end else begin
            state_d = RUN;
          end
        end
        MD_BUSY: begin
          md_busy_o = 1'b1;
          if (cnt_q == {CNT_W{1'b0}}) begin
            md_done_o = 1'b1;
            state_d   = RUN;
          end else begin
            md_hold_o = 1'b1;
            cnt_d     = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch enables/bubbles for load-use, branch flush and mult/div
// occupancy. Optional perf counters when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dx_is_load,
  input  logic       dx_is_md,
  input  logic [4:0] dx_rd,
  input  logic [4:0] fd_rs,
  input  logic [4:0] fd_rt,
  input  logic       fd_uses_rs,
  input  logic       fd_uses_rt,
  input  logic       branch_taken,
  output logic       pc_en,
  output logic       fd_en,
  output logic       dx_en,
  output logic       xm_en,
  output logic       mw_en,
  output logic       fd_bubble,
  output logic       dx_bubble,
  output logic       xm_bubble,
  output logic       md_go,
  output logic       md_busy,
  output logic       md_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  logic load_use_s;
  logic md_hold_s;
  logic flush_s;

  assign load_use_s = dx_is_load && (dx_rd != REG_ZERO) &&
                      ((fd_uses_rs && (fd_rs == dx_rd)) ||
                       (fd_uses_rt && (fd_rt == dx_rd)));

  md_occupancy_fsm #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_md_fsm (
    .clock    (clock),
    .reset    (reset),
    .md_req_i (dx_is_md),
    .md_go_o  (md_go),
    .md_busy_o(md_busy),
    .md_done_o(md_done),
    .md_hold_o(md_hold_s)
  );

  // Priority: reset > busy occupancy > md entry > branch flush > load-use.
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    xm_en     = 1'b1;
    mw_en     = 1'b1;
    fd_bubble = 1'b0;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    flush_s   = 1'b0;
    if (reset) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      dx_en = 1'b0;
      xm_en = 1'b0;
      mw_en = 1'b0;
    end else if (md_busy) begin
      if (md_hold_s) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_en     = 1'b0;
        xm_bubble = 1'b1;
      end else begin
        xm_bubble = 1'b0;
      end
    end else if (dx_is_md) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      xm_bubble = 1'b1;
    end else if (branch_taken) begin
      fd_bubble = 1'b1;
      dx_bubble = 1'b1;
      flush_s   = 1'b1;
    end else if (load_use_s) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_bubble = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= 32'h0000_0000;
      flush_q <= 32'h0000_0000;
    end else begin
      if (!pc_en && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (flush_s && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed test-plan sequences
// followed by randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MDL = 4;

  logic       clock = 1'b0;
  logic       reset, dx_is_load, dx_is_md, fd_uses_rs, fd_uses_rt, branch_taken;
  logic [4:0] dx_rd, fd_rs, fd_rt;
  logic       pc_en, fd_en, dx_en, xm_en, mw_en;
  logic       fd_bubble, dx_bubble, xm_bubble, md_go, md_busy, md_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [10:0] exp_q[$];

  // Reference model state: X-occupancy cycles still owed to the mult/div.
  int md_left   = 0;
  int ref_stall = 0;
  int ref_flush = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MD_LATENCY(MDL), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
    .dx_rd(dx_rd), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs),
    .fd_uses_rt(fd_uses_rt), .branch_taken(branch_taken),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_bubble(fd_bubble), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
    .md_go(md_go), .md_busy(md_busy), .md_done(md_done)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // Vector order: {pc,fd,dx,xm,mw, fdb,dxb,xmb, go,busy,done}
  task automatic step(input logic rst, input logic ld, input logic md,
                      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic br);
    logic [4:0] en;
    logic [2:0] bub;
    logic [2:0] mdv;
    logic       hazard;
    @(negedge clock);
    reset = rst; dx_is_load = ld; dx_is_md = md; dx_rd = rd; fd_rs = rs; fd_rt = rt;
    fd_uses_rs = urs; fd_uses_rt = urt; branch_taken = br;
    hazard = 1'b0;
    if (ld && rd != 5'd0) begin
      if (urs && rs == rd) hazard = 1'b1;
      if (urt && rt == rd) hazard = 1'b1;
    end
    en = 5'b11111; bub = 3'b000; mdv = 3'b000;
    if (rst) begin
      en = 5'b00000;
      md_left = 0;
    end else if (md_left > 0) begin
      if (md_left == 1) begin
        mdv = 3'b011;
      end else begin
        mdv = 3'b010; en = 5'b00011; bub = 3'b001;
      end
      md_left = md_left - 1;
    end else if (md) begin
      mdv = 3'b100; en = 5'b00011; bub = 3'b001;
      md_left = MDL;
    end else if (br) begin
      bub = 3'b110;
      ref_flush++;
    end else if (hazard) begin
      en = 5'b00111; bub = 3'b010;
    end
    if (!rst && !en[4]) ref_stall++;
    exp_q.push_back({en, bub, mdv});
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the scoreboard head.
  initial begin : monitor
    logic [10:0] act, expv;
    int mcyc;
    mcyc = 0;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        act = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_bubble, dx_bubble, xm_bubble,
               md_go, md_busy, md_done};
        n_cmp++;
        if (act !== expv) begin
          n_fail++;
          $display("FAIL cyc%0d outputs: got %b expected %b", mcyc, act, expv);
        end
        mcyc++;
      end
    end
  end

  initial begin : stim
    // Reset held with md and branch requested, then md entry right after.
    step(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(5);
    // Load-use on rs, then the lw moves on.
    step(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    // r0 never stalls; rt match stalls; unused operand does not.
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    // Branch with a simultaneous load-use match.
    step(1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(2);
    // Reset on cycle 2 of MD_BUSY.
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(6);
    // Randomized traffic with small register indices to provoke matches.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 9) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 5) == 0));
    end
    idle(2);
    @(negedge clock);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
`ifdef PIPE_CTRL_PERF_EN
    n_cmp++;
    if (stall_cycles !== 32'(ref_stall)) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, ref_stall);
    end
    n_cmp++;
    if (flush_events !== 32'(ref_flush)) begin
      n_fail++;
      $display("FAIL flush_events: got %0d expected %0d", flush_events, ref_flush);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
